// File: rtl/mem_pkg.sv
// Shared MEM-stage definitions: load/store operation codes, FSM state encoding
// and the access-size helpers used by the controller, load converter and ALU decode.
package mem_pkg;

    localparam logic [5:0] OP_LB  = 6'b001011;
    localparam logic [5:0] OP_LH  = 6'b001100;
    localparam logic [5:0] OP_LW  = 6'b001101;
    localparam logic [5:0] OP_LBU = 6'b001110;
    localparam logic [5:0] OP_LHU = 6'b001111;
    localparam logic [5:0] OP_SB  = 6'b010000;
    localparam logic [5:0] OP_SH  = 6'b010001;
    localparam logic [5:0] OP_SW  = 6'b010010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    // Codes outside the load/store set are treated as full-word accesses.
    function automatic size_t op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] offset);
        case (op_size(op))
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            default: return offset != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_controller_if.sv
// Data-memory request/response bus between the MEM-stage controller and memory.
interface mem_access_controller_if;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [3:0]  memByteEn;
    logic [31:0] memWdata;
    logic        memAck;
    logic [31:0] memRdata;

    modport master (
        output memReq, memWe, memAddr, memByteEn, memWdata,
        input  memAck, memRdata
    );

    modport slave (
        input  memReq, memWe, memAddr, memByteEn, memWdata,
        output memAck, memRdata
    );
endinterface

// File: rtl/lane_aligner.sv
// Byte-lane steering: byte enables, store data shifted up to its lane,
// read word shifted down so the addressed byte/half lands in the LSBs.
module lane_aligner
    import mem_pkg::*;
(
    input  logic [1:0]  offset,
    input  size_t       size,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    always_comb begin
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << offset;
            SZ_HALF: byte_en = 4'b0011 << offset;
            default: byte_en = 4'b1111;
        endcase
    end

    assign wdata     = store_data << {offset, 3'b000};
    assign load_data = rdata >> {offset, 3'b000};

endmodule

// File: rtl/mem_access_controller.sv
// MEM-stage load/store controller: stalls the pipeline while a data-memory
// access is outstanding, with alignment checks and an ack timeout.
module mem_access_controller
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      memRead,
    input  logic                      memWrite,
    input  logic [5:0]                aluSelect,
    input  logic [31:0]               address,
    input  logic [31:0]               storeData,
    mem_access_controller_if.master   mem,
    output logic                      stall,
    output logic [31:0]               loadData,
    output logic [5:0]                loadSelect,
    output logic                      loadValid,
    output logic                      misaligned,
    output logic                      accessError
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    state_t        state, state_nx;
    logic [31:0]   addr_q, wdata_q;
    logic [5:0]    op_q;
    logic          is_store_q;
    logic [CW-1:0] cnt;
    logic          ok_q, mis_q, err_q;

    logic          req_any, req_both, align_bad, in_access, timeout;
    logic [3:0]    lane_be;
    logic [31:0]   lane_wdata, lane_rdata;

    assign req_any   = memRead | memWrite;
    assign req_both  = memRead & memWrite;
    assign align_bad = is_misaligned(aluSelect, address[1:0]);
    assign in_access = state == ACCESS;
    assign timeout   = cnt == CW'(TIMEOUT_CYCLES - 1);

    lane_aligner u_lane (
        .offset     (addr_q[1:0]),
        .size       (op_size(op_q)),
        .store_data (wdata_q),
        .rdata      (mem.memRdata),
        .byte_en    (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_rdata)
    );

    // Bus outputs are forced to zero outside ACCESS so reset clears them at once.
    assign mem.memReq    = in_access;
    assign mem.memWe     = in_access & is_store_q;
    assign mem.memAddr   = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem.memByteEn = in_access ? lane_be : 4'h0;
    assign mem.memWdata  = in_access ? lane_wdata : 32'h0;

    assign loadValid   = (state == DONE) & ok_q;
    assign misaligned  = (state == DONE) & mis_q;
    assign accessError = (state == DONE) & err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        case (state)
            IDLE: begin
                if (req_any && !reset) begin
                    stall    = 1'b1;
                    state_nx = (req_both || align_bad) ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (mem.memAck || timeout) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            op_q       <= '0;
            is_store_q <= 1'b0;
            cnt        <= '0;
            ok_q       <= 1'b0;
            mis_q      <= 1'b0;
            err_q      <= 1'b0;
            loadData   <= '0;
            loadSelect <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        addr_q     <= address;
                        wdata_q    <= storeData;
                        op_q       <= aluSelect;
                        is_store_q <= memWrite;
                        cnt        <= '0;
                        ok_q       <= 1'b0;
                        mis_q      <= !req_both && align_bad;
                        err_q      <= req_both;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    // Ack wins over a timeout landing in the same cycle.
                    if (mem.memAck) begin
                        if (!is_store_q) begin
                            loadData   <= lane_rdata;
                            loadSelect <= op_q;
                            ok_q       <= 1'b1;
                        end
                    end else if (timeout) begin
                        err_q    <= 1'b1;
                        loadData <= '0;
                    end
                end
                default: begin
                    ok_q  <= 1'b0;
                    mis_q <= 1'b0;
                    err_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench for mem_access_controller: hand-computed vectors for loads,
// stores, alignment rejection, timeout, reset abort and conflicting requests.
module tb_mem_access_controller;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memRead = 1'b0, memWrite = 1'b0;
    logic [5:0]  aluSelect = '0;
    logic [31:0] address = '0, storeData = '0;
    logic        stall, loadValid, misaligned, accessError;
    logic [31:0] loadData;
    logic [5:0]  loadSelect;
    int          tests = 0, fails = 0;

    mem_access_controller_if bus ();

    mem_access_controller #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .aluSelect   (aluSelect),
        .address     (address),
        .storeData   (storeData),
        .mem         (bus),
        .stall       (stall),
        .loadData    (loadData),
        .loadSelect  (loadSelect),
        .loadValid   (loadValid),
        .misaligned  (misaligned),
        .accessError (accessError)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic rd, input logic wr, input logic [5:0] op,
                           input logic [31:0] a, input logic [31:0] d);
        memRead = rd; memWrite = wr; aluSelect = op; address = a; storeData = d;
    endtask

    task automatic idle_inputs();
        memRead = 1'b0; memWrite = 1'b0;
    endtask

    initial begin
        int  req_cycles;
        bit  seen;
        bus.memAck = 1'b0;
        bus.memRdata = '0;

        // Reset state before any clock edge
        #3;
        chk("rst_memreq", 32'(bus.memReq), 32'd0);
        chk("rst_stall",  32'(stall), 32'd0);
        chk("rst_flags",  32'({loadValid, misaligned, accessError}), 32'd0);
        chk("rst_ldata",  loadData, 32'h0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // LB at 0x1003, ack in second ACCESS cycle
        request(1, 0, OP_LB, 32'h0000_1003, 32'h0); #1;
        chk("lb_req_stall", 32'(stall), 32'd1);
        chk("lb_req_noreq", 32'(bus.memReq), 32'd0);
        tick(); idle_inputs(); #1;
        chk("lb_acc_req",  32'(bus.memReq), 32'd1);
        chk("lb_acc_we",   32'(bus.memWe), 32'd0);
        chk("lb_acc_be",   32'(bus.memByteEn), 32'h8);
        chk("lb_acc_addr", bus.memAddr, 32'h0000_1000);
        chk("lb_acc_stall", 32'(stall), 32'd1);
        tick(); bus.memAck = 1'b1; bus.memRdata = 32'hA500_0000; #1;
        chk("lb_ack_stall", 32'(stall), 32'd1);
        chk("lb_ack_novalid", 32'(loadValid), 32'd0);
        tick(); bus.memAck = 1'b0; #1;
        chk("lb_done_valid", 32'(loadValid), 32'd1);
        chk("lb_done_data",  loadData, 32'h0000_00A5);
        chk("lb_done_sel",   32'(loadSelect), 32'(OP_LB));
        chk("lb_done_stall", 32'(stall), 32'd0);
        chk("lb_done_req",   32'(bus.memReq), 32'd0);
        tick(); #1;
        chk("lb_after_valid", 32'(loadValid), 32'd0);

        // SH at 0x2002
        request(0, 1, OP_SH, 32'h0000_2002, 32'h0000_1234);
        tick(); idle_inputs(); #1;
        chk("sh_we",    32'(bus.memWe), 32'd1);
        chk("sh_be",    32'(bus.memByteEn), 32'hC);
        chk("sh_wdata", bus.memWdata, 32'h1234_0000);
        chk("sh_addr",  bus.memAddr, 32'h0000_2000);
        bus.memAck = 1'b1;
        tick(); bus.memAck = 1'b0; #1;
        chk("sh_done_flags", 32'({loadValid, misaligned, accessError}), 32'd0);
        chk("sh_done_req", 32'(bus.memReq), 32'd0);
        tick();

        // SB at 0x0001 lands in lane 1
        request(0, 1, OP_SB, 32'h0000_0001, 32'h0000_00AB);
        tick(); idle_inputs(); #1;
        chk("sb_be",    32'(bus.memByteEn), 32'h2);
        chk("sb_wdata", bus.memWdata, 32'h0000_AB00);
        bus.memAck = 1'b1;
        tick(); bus.memAck = 1'b0;
        tick();

        // LW at 0x3001 is misaligned
        request(1, 0, OP_LW, 32'h0000_3001, 32'h0); #1;
        chk("mis_req_stall", 32'(stall), 32'd1);
        chk("mis_req_noreq", 32'(bus.memReq), 32'd0);
        tick(); idle_inputs(); #1;
        chk("mis_pulse", 32'({loadValid, misaligned, accessError}), 32'b010);
        chk("mis_noreq", 32'(bus.memReq), 32'd0);
        chk("mis_stall", 32'(stall), 32'd0);
        tick(); #1;
        chk("mis_cleared", 32'(misaligned), 32'd0);

        // LW with no ack: 16 request cycles, then error with loadData cleared
        request(1, 0, OP_LW, 32'h0000_3000, 32'h0);
        req_cycles = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick(); idle_inputs(); #1;
            if (bus.memReq) req_cycles++;
            if (accessError) begin
                seen = 1;
                chk("to_ldata", loadData, 32'h0);
                chk("to_only_err", 32'({loadValid, misaligned}), 32'd0);
            end
        end
        chk("to_seen", 32'(seen), 32'd1);
        chk("to_req_cycles", 32'(req_cycles), 32'd16);
        tick();

        // Ack on the final allowed cycle beats the timeout
        request(1, 0, OP_LW, 32'h0000_3004, 32'h0);
        for (int i = 0; i < 16; i++) begin
            tick(); idle_inputs();
            if (i == 15) begin bus.memAck = 1'b1; bus.memRdata = 32'hCAFE_F00D; end
        end
        tick(); bus.memAck = 1'b0; #1;
        chk("edge_valid", 32'(loadValid), 32'd1);
        chk("edge_noerr", 32'(accessError), 32'd0);
        chk("edge_data",  loadData, 32'hCAFE_F00D);
        tick();

        // Reset in the middle of ACCESS, then no retry
        request(1, 0, OP_LHU, 32'h0000_4002, 32'h0);
        tick(); idle_inputs(); #1;
        chk("rmid_req_before", 32'(bus.memReq), 32'd1);
        #1 reset = 1'b1; #1;
        chk("rmid_req",   32'(bus.memReq), 32'd0);
        chk("rmid_stall", 32'(stall), 32'd0);
        tick(); reset = 1'b0;
        tick(); #1;
        chk("rmid_noretry", 32'(bus.memReq), 32'd0);

        // LHU at 0x4002 after reset
        request(1, 0, OP_LHU, 32'h0000_4002, 32'h0);
        tick(); idle_inputs(); bus.memAck = 1'b1; bus.memRdata = 32'hBEEF_0000; #1;
        chk("lhu_be", 32'(bus.memByteEn), 32'hC);
        tick(); bus.memAck = 1'b0; #1;
        chk("lhu_valid", 32'(loadValid), 32'd1);
        chk("lhu_data",  loadData, 32'h0000_BEEF);
        chk("lhu_sel",   32'(loadSelect), 32'(OP_LHU));
        tick();

        // memRead and memWrite together
        request(1, 1, OP_LW, 32'h0000_5000, 32'h0); #1;
        chk("both_noreq", 32'(bus.memReq), 32'd0);
        tick(); idle_inputs(); #1;
        chk("both_pulse", 32'({loadValid, misaligned, accessError}), 32'b001);
        chk("both_noreq_done", 32'(bus.memReq), 32'd0);
        tick(); #1;
        chk("both_cleared", 32'(accessError), 32'd0);

        // Stray ack while idle is ignored
        bus.memAck = 1'b1; bus.memRdata = 32'h1111_1111;
        tick(); bus.memAck = 1'b0; #1;
        chk("stray_valid", 32'(loadValid), 32'd0);
        chk("stray_data",  loadData, 32'h0000_BEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_controller.md
MEM_ACCESS_CONTROLLER -- requirements
Module: mem_access_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum cycles to wait for memAck before aborting an access.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-high.
REQ-004 memRead  input  1  MEM-stage load request.
REQ-005 memWrite  input  1  MEM-stage store request.
REQ-006 aluSelect  input  6  MEM-stage operation code (load/store codes from shared package).
REQ-007 address  input  32  byte address from ALU.
REQ-008 storeData  input  32  rs2 value; store bytes taken from LSBs.
REQ-009 memReq  output  1  access request to data memory, held until memAck or abort.
REQ-010 memWe  output  1  write strobe, valid with memReq.
REQ-011 memAddr  output  32  word-aligned address ({address[31:2],2'b00}).
REQ-012 memByteEn  output  4  byte lanes written (stores) or read (loads).
REQ-013 memWdata  output  32  storeData shifted to the addressed lane(s).
REQ-014 memAck  input  1  memory completion; memRdata valid in the same cycle.
REQ-015 memRdata  input  32  word read from memory.
REQ-016 stall  output  1  freeze IF/ID/EX/MEM while access in progress.
REQ-017 loadData  output  32  read word shifted right by 8*address[1:0]; feeds the writeback load converter inputData.
REQ-018 loadSelect  output  6  registered aluSelect of the completed load; feeds the converter aluSelect.
REQ-019 loadValid  output  1  one-cycle pulse: loadData/loadSelect valid.
REQ-020 misaligned  output  1  one-cycle pulse: misaligned access rejected.
REQ-021 accessError  output  1  one-cycle pulse: timeout or memRead and memWrite both asserted.

Function
REQ-022 Codes: LB 001011, LH 001100, LW 001101, LBU 001110, LHU 001111, SB 010000, SH 010001, SW 010010.
REQ-023 FSM states IDLE, ACCESS, DONE.
REQ-024 IDLE with memRead xor memWrite, aligned: latch address/op/data, stall=1 combinationally that cycle, go ACCESS.
REQ-025 Alignment: halfword ops need address[0]=0; word ops need address[1:0]=00; else no memory access, go DONE with misaligned=1.
REQ-026 IDLE with memRead and memWrite both high: no memory access, go DONE with accessError=1.
REQ-027 ACCESS: memReq=1, memWe=1 for stores only, stall=1; inputs ignored; address/data held stable.
REQ-028 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; same rule for loads.
REQ-029 memAck in ACCESS: capture shifted memRdata (loads), go DONE; read-to-loadValid latency is 1 cycle after ack.
REQ-030 Wait counter: cleared on entry to ACCESS, increments each ACCESS cycle; reaching TIMEOUT_CYCLES without memAck -> drop memReq, go DONE with accessError=1, loadData=0.
REQ-031 memAck in same cycle as timeout: ack wins, no error.
REQ-032 DONE (exactly 1 cycle): stall=0, outputs memReq=0; pulse loadValid for successful loads, or the pending error flag; new requests ignored; next state IDLE.
REQ-033 At most one of loadValid, misaligned, accessError high in any cycle; all zero outside DONE.
REQ-034 memAck outside ACCESS ignored.

Reset
REQ-035 reset asserted (any time, including mid-ACCESS): state IDLE, counter 0, memReq=0, memWe=0, memByteEn=0, memAddr=0, memWdata=0, stall=0, loadData=0, loadSelect=0, loadValid=0, misaligned=0, accessError=0, immediately without waiting for clk.
REQ-036 An access aborted by reset is not retried.

Structure
REQ-037 Operation codes and FSM state encoding live in shared package mem_pkg, also used by the load converter and ALU decode.
REQ-038 Lane logic (byte-enable, store shift, load shift) as one combinational sub-module lane_aligner; FSM and counter in the top.

Verification
REQ-039 LB at 0x1003, memRdata=0xA5000000, ack after 2 cycles -> memByteEn=1000, loadData=0x000000A5, loadSelect=001011, loadValid one cycle after ack; stall high 3 cycles.
REQ-040 SH at 0x2002, storeData=0x00001234 -> memWe=1, memByteEn=1100, memWdata=0x12340000, memAddr=0x2000.
REQ-041 LW at 0x3001 -> no memReq, misaligned pulse in next cycle, stall only in request cycle.
REQ-042 LW, memAck never asserted, TIMEOUT_CYCLES=16 -> memReq high 16 cycles, then accessError pulse, loadData=0.
REQ-043 reset asserted mid-ACCESS -> memReq and stall 0 before next clk edge; following LHU 0x4002 with memRdata=0xBEEF0000 -> loadData=0x0000BEEF, loadSelect=001111.
REQ-044 memRead and memWrite both high -> no memReq, accessError pulse one cycle later.
